// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and 8N1 frame constants,
// common to uart_tx and uart_rx.
package uart_pkg;

   typedef logic [2:0] uart_state_t;

   localparam uart_state_t IDLE      = 3'd0;
   localparam uart_state_t START     = 3'd1;
   localparam uart_state_t DATA      = 3'd2;
   localparam uart_state_t STOP      = 3'd3;
   localparam uart_state_t WAIT_HIGH = 3'd4;

   localparam int   FRAME_DATA_BITS = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous serial pad input; both flops
// reset to the line idle level so no false start bit appears after reset.
module uart_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: non-blocking assignments make meta -> q a genuine two-stage shift;
   // blocking ones would collapse both flops into one.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= UART_IDLE_LEVEL;
         q    <= UART_IDLE_LEVEL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling each bit at its midpoint, with one-cycle
// valid/error pulses and a running byte checksum.
// Define UART_RX_SYNC_EN to insert a two-flop synchronizer on rx.
module uart_rx
   import uart_pkg::*;
#(
   parameter int clocks_per_bit = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_error,
   output logic [31:0] out_sum
);

   localparam int             CW       = $clog2(clocks_per_bit);
   localparam logic [CW-1:0]  HALF_BIT = CW'(clocks_per_bit / 2 - 1);
   localparam logic [CW-1:0]  FULL_BIT = CW'(clocks_per_bit - 1);
   localparam logic [3:0]     LAST_BIT = 4'(FRAME_DATA_BITS - 1);

   logic                       rxs;
   uart_state_t                state;
   logic [CW-1:0]              cycle_count;
   logic [3:0]                 bit_count;
   logic [FRAME_DATA_BITS-1:0] shift;

`ifdef UART_RX_SYNC_EN
   uart_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rxs)
   );
`else
   assign rxs = rx;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cycle_count <= '0;
         bit_count   <= '0;
         shift       <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_error   <= 1'b0;
         out_sum     <= '0;
      end else begin
         out_valid <= 1'b0;
         out_error <= 1'b0;
         case (state)
            IDLE: begin
               if (rxs != UART_IDLE_LEVEL) begin
                  state       <= START;
                  cycle_count <= HALF_BIT;
               end
            end
            START: begin
               // A start bit that is gone by its midpoint is treated as a glitch.
               if (cycle_count != '0) begin
                  cycle_count <= cycle_count - CW'(1);
               end else if (rxs != UART_IDLE_LEVEL) begin
                  state       <= DATA;
                  cycle_count <= FULL_BIT;
                  bit_count   <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (cycle_count != '0) begin
                  cycle_count <= cycle_count - CW'(1);
               end else begin
                  shift       <= {rxs, shift[FRAME_DATA_BITS-1:1]};
                  bit_count   <= bit_count + 4'd1;
                  cycle_count <= FULL_BIT;
                  if (bit_count == LAST_BIT) begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               if (cycle_count != '0) begin
                  cycle_count <= cycle_count - CW'(1);
               end else if (rxs == UART_IDLE_LEVEL) begin
                  out_data  <= shift;
                  out_valid <= 1'b1;
                  out_sum   <= out_sum + 32'(shift);
                  state     <= IDLE;
               end else begin
                  out_error <= 1'b1;
                  state     <= WAIT_HIGH;
               end
            end
            WAIT_HIGH: begin
               // A break or stuck-low line must return high before a new frame is accepted.
               if (rxs == UART_IDLE_LEVEL) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a frame driver pushes expected results,
// a negedge monitor pops and compares whenever a pulse appears.
module tb_uart_rx;

   localparam int CPB = 4;
`ifdef UART_RX_SYNC_EN
   localparam int LATENCY = 41;
`else
   localparam int LATENCY = 39;
`endif

   typedef struct {
      bit          is_err;
      logic [7:0]  data;
      logic [31:0] sum;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_error;
   logic [31:0] out_sum;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          fall_cyc = 0;
   int          last_valid_cyc = 0;

   exp_t        exp_q[$];
   logic [31:0] model_sum  = 0;
   logic [7:0]  model_data = 0;

   uart_rx #(.clocks_per_bit(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_error (out_error),
      .out_sum   (out_sum)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && (out_valid || out_error)) begin
         check("pulse_exclusive", 32'(out_valid & out_error), 32'd0);
         check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_kind_error", 32'(out_error), 32'(e.is_err));
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_sum", out_sum, e.sum);
            if (out_valid) last_valid_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      exp_q.delete();
      model_sum  = 0;
      model_data = 0;
   endtask

   // Reference: a good frame yields its byte and the new sum; a low stop bit
   // yields an error with data and sum left as they were.
   task automatic send_frame(input logic [7:0] b, input bit good);
      exp_t e;
      if (good) begin
         model_sum  = model_sum + {24'd0, b};
         model_data = b;
      end
      e.is_err = !good;
      e.data   = model_data;
      e.sum    = model_sum;
      exp_q.push_back(e);
      rx = 1'b0;
      fall_cyc = cyc;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) tick();
      end
      rx = good ? 1'b1 : 1'b0;
      repeat (CPB) tick();
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check(name, exp_q.size(), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();

      // 1: idle line after reset
      idle(100);
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_out_sum", out_sum, 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_error", 32'(out_error), 32'd0);

      // 2: single byte with latency measurement
      send_frame(8'h55, 1'b1);
      drain("drain_single");
      check("latency", 32'(last_valid_cyc - fall_cyc), 32'(LATENCY));
      check("single_sum", out_sum, 32'h55);

      // 3: back-to-back frames, no idle gap
      do_reset();
      idle(5);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'hA5, 1'b1);
      drain("drain_b2b");
      check("b2b_sum", out_sum, 32'h1A4);

      // 4: one-cycle glitch is rejected
      rx = 1'b0;
      tick();
      idle(30);
      check("glitch_data", 32'(out_data), 32'hA5);
      check("glitch_sum", out_sum, 32'h1A4);

      // 5: framing error, stuck-low line, then recovery
      do_reset();
      idle(5);
      send_frame(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (20) tick();
      idle(4);
      send_frame(8'h12, 1'b1);
      drain("drain_framing");
      check("framing_data", 32'(out_data), 32'h12);
      check("framing_sum", out_sum, 32'h12);

      // 6: reset in the middle of a frame
      idle(5);
      rx = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 4; i++) begin
         rx = ((8'h99 >> i) & 8'h01) != 0;
         repeat (CPB) tick();
      end
      do_reset();
      idle(10);
      check("midreset_data", 32'(out_data), 32'd0);
      check("midreset_sum", out_sum, 32'd0);
      send_frame(8'h42, 1'b1);
      drain("drain_midreset");
      check("midreset_next_sum", out_sum, 32'h42);

      // Random traffic: gaps, occasional framing errors with low holds
      for (int n = 0; n < 40; n++) begin
         logic [7:0] b;
         bit         good;
         b    = 8'($urandom);
         good = ($urandom_range(0, 7) != 0);
         send_frame(b, good);
         if (!good) begin
            rx = 1'b0;
            repeat ($urandom_range(0, 10)) tick();
            idle($urandom_range(1, 3));
         end else begin
            idle($urandom_range(0, 3));
         end
      end
      drain("drain_random");
      check("random_sum", out_sum, model_sum);
      check("random_data", 32'(out_data), 32'(model_data));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
